// File: rtl/dbus_arb_pkg.sv
// Shared types for the core data-bus arbiter: FSM state, grant encoding,
// request/response structs for the load unit, the store drain and the data bus.
package dbus_arb_pkg;

    localparam int STARVE_MAX_DEF = 8;

    // Addresses sharing bits [63:3] fall in the same 8-byte granule.
    localparam logic [63:0] GRAN_MASK = 64'hFFFF_FFFF_FFFF_FFF8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOAD  = 2'd1,
        ARB_STORE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_LOAD  = 2'd1,
        GNT_STORE = 2'd2
    } arb_gnt_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
    } mread_req;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } mwrite_req;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    localparam dbus_req_t DBUS_REQ_IDLE = '{
        valid:  1'b0,
        addr:   64'h0,
        size:   3'd0,
        strobe: 8'h00,
        data:   64'h0
    };

    // True when both addresses hit the same 8-byte granule.
    function automatic logic same_granule(input logic [63:0] a, input logic [63:0] b);
        return ((a ^ b) & GRAN_MASK) == 64'h0;
    endfunction

endpackage

// File: rtl/dbus_arb_pick.sv
// Pure combinational grant priority used while the arbiter is idle.
module dbus_arb_pick
    import dbus_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             load_valid,
    input  logic             store_valid,
    input  logic             same_gran,
    input  logic             flush,
    input  logic [CNT_W-1:0] starve_cnt,
    output arb_gnt_t         gnt
);

    // Starved store first, then same-granule store (RAW), then unflushed load, then store.
    always_comb begin
        gnt = GNT_NONE;
        if (store_valid && (starve_cnt == CNT_W'(STARVE_MAX))) begin
            gnt = GNT_STORE;
        end else if (load_valid && store_valid && same_gran) begin
            gnt = GNT_STORE;
        end else if (load_valid && !flush) begin
            gnt = GNT_LOAD;
        end else if (store_valid) begin
            gnt = GNT_STORE;
        end else begin
            gnt = GNT_NONE;
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Shares the core data bus between speculative loads and the committed-store
// drain. One transaction in flight; the bus request is registered and held
// until data_ok, and squashed loads complete on the bus but return nothing.
module dbus_arbiter
    import dbus_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  mread_req    load_req,
    output logic        load_ready,
    output logic        load_resp_valid,
    output logic [63:0] load_resp_data,
    input  mwrite_req   store_req,
    output logic        store_ready,
    output logic        store_done,
    output dbus_req_t   dreq,
    input  dbus_resp_t  dresp
);

    arb_state_t       state_q, state_d;
    dbus_req_t        req_q, req_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             squash_q, squash_d;
    logic             load_resp_valid_q, load_resp_valid_d;
    logic [63:0]      load_resp_data_q, load_resp_data_d;
    logic             store_done_q, store_done_d;

    arb_gnt_t         gnt_s;
    logic             load_ready_s, store_ready_s;

    dbus_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .load_valid  (load_req.valid),
        .store_valid (store_req.valid),
        .same_gran   (same_granule(load_req.addr, store_req.addr)),
        .flush       (flush),
        .starve_cnt  (starve_cnt_q),
        .gnt         (gnt_s)
    );

    // Next-state, request latch, squash tracking and response pulses.
    always_comb begin
        state_d           = state_q;
        req_d             = req_q;
        squash_d          = squash_q;
        load_resp_valid_d = 1'b0;
        load_resp_data_d  = load_resp_data_q;
        store_done_d      = 1'b0;
        load_ready_s      = 1'b0;
        store_ready_s     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                squash_d = 1'b0;
                if (gnt_s == GNT_LOAD) begin
                    load_ready_s = 1'b1;
                    req_d        = '{valid: 1'b1, addr: load_req.addr, size: load_req.size,
                                     strobe: 8'h00, data: 64'h0};
                    state_d      = ARB_LOAD;
                end else if (gnt_s == GNT_STORE) begin
                    store_ready_s = 1'b1;
                    req_d         = '{valid: 1'b1, addr: store_req.addr, size: store_req.size,
                                      strobe: store_req.strobe, data: store_req.data};
                    state_d       = ARB_STORE;
                end else begin
                    req_d   = DBUS_REQ_IDLE;
                    state_d = ARB_IDLE;
                end
            end
            ARB_LOAD: begin
                // The bus beat is never abandoned; a flush only suppresses the response.
                if (dresp.data_ok) begin
                    state_d  = ARB_IDLE;
                    req_d    = DBUS_REQ_IDLE;
                    squash_d = 1'b0;
                    if (!(squash_q || flush)) begin
                        load_resp_valid_d = 1'b1;
                        load_resp_data_d  = dresp.data;
                    end else begin
                        load_resp_valid_d = 1'b0;
                    end
                end else begin
                    squash_d = squash_q | flush;
                end
            end
            ARB_STORE: begin
                if (dresp.data_ok) begin
                    state_d      = ARB_IDLE;
                    req_d        = DBUS_REQ_IDLE;
                    store_done_d = 1'b1;
                end else begin
                    state_d = ARB_STORE;
                end
            end
            default: begin
                state_d  = ARB_IDLE;
                req_d    = DBUS_REQ_IDLE;
                squash_d = 1'b0;
            end
        endcase
    end

    // Starvation counter: counts every cycle a valid store is not granted, saturating.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (store_ready_s) begin
            starve_cnt_d = {CNT_W{1'b0}};
        end else if (store_req.valid && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ARB_IDLE;
            req_q             <= DBUS_REQ_IDLE;
            starve_cnt_q      <= {CNT_W{1'b0}};
            squash_q          <= 1'b0;
            load_resp_valid_q <= 1'b0;
            load_resp_data_q  <= 64'h0;
            store_done_q      <= 1'b0;
        end else begin
            state_q           <= state_d;
            req_q             <= req_d;
            starve_cnt_q      <= starve_cnt_d;
            squash_q          <= squash_d;
            load_resp_valid_q <= load_resp_valid_d;
            load_resp_data_q  <= load_resp_data_d;
            store_done_q      <= store_done_d;
        end
    end

    // Ready is the accept handshake and must answer in the request cycle; held low in reset.
    assign load_ready      = load_ready_s & ~reset;
    assign store_ready     = store_ready_s & ~reset;
    assign dreq            = req_q;
    assign load_resp_valid = load_resp_valid_q;
    assign load_resp_data  = load_resp_data_q;
    assign store_done      = store_done_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: reset, single load, RAW ordering,
// store starvation, load squash on flush, reset mid-store.
module tb_dbus_arbiter;
    import dbus_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    mread_req    load_req;
    logic        load_ready;
    logic        load_resp_valid;
    logic [63:0] load_resp_data;
    mwrite_req   store_req;
    logic        store_ready;
    logic        store_done;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;

    int pass_cnt;
    int total_cnt;

    dbus_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .load_req        (load_req),
        .load_ready      (load_ready),
        .load_resp_valid (load_resp_valid),
        .load_resp_data  (load_resp_data),
        .store_req       (store_req),
        .store_ready     (store_ready),
        .store_done      (store_done),
        .dreq            (dreq),
        .dresp           (dresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge (input drive point).
    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    // Advance to the falling edge (sample point).
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load_req  = '{valid: 1'b1, addr: 64'h8000_0010, size: 3'd3};
        store_req = '{valid: 1'b1, addr: 64'h8000_3000, size: 3'd3, strobe: 8'hFF, data: 64'h1};
        for (int i = 0; i < 3; i++) begin
            smp();
            total_cnt++;
            if ({load_ready, store_ready, dreq.valid, load_resp_valid, store_done} !== 5'b00000)
                $display("FAIL reset_ctl[%0d]: got %b want 00000", i,
                         {load_ready, store_ready, dreq.valid, load_resp_valid, store_done});
            else pass_cnt++;
            total_cnt++;
            if (load_resp_data !== 64'h0 || dreq.addr !== 64'h0 || dreq.strobe !== 8'h00)
                $display("FAIL reset_data[%0d]: got data %h addr %h strb %h want 0", i,
                         load_resp_data, dreq.addr, dreq.strobe);
            else pass_cnt++;
            nx();
        end
        reset = 1'b0;
        load_req.valid  = 1'b0;
        store_req.valid = 1'b0;
        nx();
    endtask

    task automatic test_single_load();
        load_req = '{valid: 1'b1, addr: 64'h8000_0010, size: 3'd3};
        smp();
        total_cnt++;
        if ({load_ready, store_ready, dreq.valid} !== 3'b100)
            $display("FAIL t2_accept: got %b want 100", {load_ready, store_ready, dreq.valid});
        else pass_cnt++;
        nx();
        load_req.valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) begin
                dresp = '{data_ok: 1'b1, data: 64'h0000_0000_DEAD_BEEF};
            end
            smp();
            total_cnt++;
            if (dreq.valid !== 1'b1 || dreq.addr !== 64'h8000_0010 || dreq.strobe !== 8'h00
                || load_resp_valid !== 1'b0)
                $display("FAIL t2_bus[N+%0d]: got v%b a%h s%h rv%b want v1 a8000_0010 s00 rv0",
                         i, dreq.valid, dreq.addr, dreq.strobe, load_resp_valid);
            else pass_cnt++;
            nx();
        end
        dresp = '{data_ok: 1'b0, data: 64'h0};
        smp();
        total_cnt++;
        if (load_resp_valid !== 1'b1 || load_resp_data !== 64'h0000_0000_DEAD_BEEF || dreq.valid !== 1'b0)
            $display("FAIL t2_resp: got rv%b d%h dv%b want rv1 dDEADBEEF dv0",
                     load_resp_valid, load_resp_data, dreq.valid);
        else pass_cnt++;
        nx();
        smp();
        total_cnt++;
        if (load_resp_valid !== 1'b0)
            $display("FAIL t2_pulse: got %b want 0", load_resp_valid);
        else pass_cnt++;
        nx();
    endtask

    task automatic test_raw_order();
        load_req  = '{valid: 1'b1, addr: 64'h8000_1008, size: 3'd3};
        store_req = '{valid: 1'b1, addr: 64'h8000_100C, size: 3'd2, strobe: 8'hF0,
                      data: 64'h1122_3344_5566_7788};
        smp();
        total_cnt++;
        if ({load_ready, store_ready} !== 2'b01)
            $display("FAIL t3_grant: got %b want 01", {load_ready, store_ready});
        else pass_cnt++;
        nx();
        store_req.valid = 1'b0;
        smp();
        total_cnt++;
        if (dreq.valid !== 1'b1 || dreq.addr !== 64'h8000_100C || dreq.strobe !== 8'hF0 || load_ready !== 1'b0)
            $display("FAIL t3_store_bus: got v%b a%h s%h lr%b want v1 a8000_100C sF0 lr0",
                     dreq.valid, dreq.addr, dreq.strobe, load_ready);
        else pass_cnt++;
        nx();
        dresp.data_ok = 1'b1;
        smp();
        nx();
        dresp.data_ok = 1'b0;
        smp();
        total_cnt++;
        if ({store_done, load_resp_valid, load_ready, dreq.valid} !== 4'b1010)
            $display("FAIL t3_bubble: got %b want 1010",
                     {store_done, load_resp_valid, load_ready, dreq.valid});
        else pass_cnt++;
        nx();
        load_req.valid = 1'b0;
        smp();
        total_cnt++;
        if (dreq.valid !== 1'b1 || dreq.addr !== 64'h8000_1008 || dreq.strobe !== 8'h00 || store_done !== 1'b0)
            $display("FAIL t3_load_bus: got v%b a%h s%h sd%b want v1 a8000_1008 s00 sd0",
                     dreq.valid, dreq.addr, dreq.strobe, store_done);
        else pass_cnt++;
        nx();
        dresp = '{data_ok: 1'b1, data: 64'h55};
        smp();
        nx();
        dresp = '{data_ok: 1'b0, data: 64'h0};
        smp();
        total_cnt++;
        if (load_resp_valid !== 1'b1 || load_resp_data !== 64'h55)
            $display("FAIL t3_load_resp: got rv%b d%h want rv1 d55", load_resp_valid, load_resp_data);
        else pass_cnt++;
        nx();
    endtask

    task automatic test_starvation();
        load_req  = '{valid: 1'b1, addr: 64'h8000_2000, size: 3'd3};
        store_req = '{valid: 1'b1, addr: 64'h8000_3000, size: 3'd3, strobe: 8'hFF,
                      data: 64'hAAAA_AAAA_AAAA_AAAA};
        for (int i = 0; i < 4; i++) begin
            smp();
            total_cnt++;
            if ({load_ready, store_ready} !== 2'b10 || dut.starve_cnt_q !== 4'(2 * i))
                $display("FAIL t4_load_win[%0d]: got rdy %b cnt %0d want 10 cnt %0d", i,
                         {load_ready, store_ready}, dut.starve_cnt_q, 2 * i);
            else pass_cnt++;
            nx();
            dresp.data_ok = 1'b1;
            smp();
            total_cnt++;
            if (dreq.valid !== 1'b1 || dreq.addr !== 64'h8000_2000)
                $display("FAIL t4_load_bus[%0d]: got v%b a%h want v1 a8000_2000", i, dreq.valid, dreq.addr);
            else pass_cnt++;
            nx();
            dresp.data_ok = 1'b0;
        end
        smp();
        total_cnt++;
        if ({load_ready, store_ready} !== 2'b01 || dut.starve_cnt_q !== 4'd8)
            $display("FAIL t4_forced: got rdy %b cnt %0d want 01 cnt 8",
                     {load_ready, store_ready}, dut.starve_cnt_q);
        else pass_cnt++;
        nx();
        load_req.valid  = 1'b0;
        store_req.valid = 1'b0;
        smp();
        total_cnt++;
        if (dut.starve_cnt_q !== 4'd0 || dreq.addr !== 64'h8000_3000 || dreq.strobe !== 8'hFF)
            $display("FAIL t4_store_bus: got cnt %0d a%h s%h want cnt 0 a8000_3000 sFF",
                     dut.starve_cnt_q, dreq.addr, dreq.strobe);
        else pass_cnt++;
        nx();
        dresp.data_ok = 1'b1;
        smp();
        nx();
        dresp.data_ok = 1'b0;
        smp();
        total_cnt++;
        if (store_done !== 1'b1)
            $display("FAIL t4_done: got %b want 1", store_done);
        else pass_cnt++;
        nx();
    endtask

    task automatic test_flush();
        load_req = '{valid: 1'b1, addr: 64'h8000_4000, size: 3'd3};
        flush    = 1'b1;
        smp();
        total_cnt++;
        if (load_ready !== 1'b0)
            $display("FAIL t5_idle_block: got %b want 0", load_ready);
        else pass_cnt++;
        nx();
        flush = 1'b0;
        smp();
        total_cnt++;
        if (load_ready !== 1'b1 || dreq.valid !== 1'b0)
            $display("FAIL t5_accept: got lr%b dv%b want lr1 dv0", load_ready, dreq.valid);
        else pass_cnt++;
        nx();
        load_req.valid = 1'b0;
        flush          = 1'b1;
        smp();
        nx();
        flush = 1'b0;
        smp();
        total_cnt++;
        if (dreq.valid !== 1'b1 || dreq.addr !== 64'h8000_4000)
            $display("FAIL t5_held: got v%b a%h want v1 a8000_4000", dreq.valid, dreq.addr);
        else pass_cnt++;
        nx();
        dresp = '{data_ok: 1'b1, data: 64'h77};
        smp();
        total_cnt++;
        if (dreq.valid !== 1'b1 || dreq.addr !== 64'h8000_4000)
            $display("FAIL t5_held_ok: got v%b a%h want v1 a8000_4000", dreq.valid, dreq.addr);
        else pass_cnt++;
        nx();
        dresp    = '{data_ok: 1'b0, data: 64'h0};
        load_req = '{valid: 1'b1, addr: 64'h8000_4008, size: 3'd3};
        smp();
        total_cnt++;
        if ({load_resp_valid, dreq.valid, load_ready} !== 3'b001)
            $display("FAIL t5_squashed: got %b want 001", {load_resp_valid, dreq.valid, load_ready});
        else pass_cnt++;
        nx();
        load_req.valid = 1'b0;
        dresp = '{data_ok: 1'b1, data: 64'h99};
        smp();
        total_cnt++;
        if (load_resp_valid !== 1'b0)
            $display("FAIL t5_no_pulse: got %b want 0", load_resp_valid);
        else pass_cnt++;
        nx();
        dresp = '{data_ok: 1'b0, data: 64'h0};
        smp();
        total_cnt++;
        if (load_resp_valid !== 1'b1 || load_resp_data !== 64'h99)
            $display("FAIL t5_next_load: got rv%b d%h want rv1 d99", load_resp_valid, load_resp_data);
        else pass_cnt++;
        nx();
    endtask

    task automatic test_reset_mid_store();
        store_req = '{valid: 1'b1, addr: 64'h8000_5000, size: 3'd3, strobe: 8'h0F, data: 64'h42};
        smp();
        total_cnt++;
        if (store_ready !== 1'b1)
            $display("FAIL t6_accept: got %b want 1", store_ready);
        else pass_cnt++;
        nx();
        store_req.valid = 1'b0;
        smp();
        total_cnt++;
        if (dreq.valid !== 1'b1 || dreq.strobe !== 8'h0F)
            $display("FAIL t6_bus: got v%b s%h want v1 s0F", dreq.valid, dreq.strobe);
        else pass_cnt++;
        nx();
        reset = 1'b1;
        nx();
        reset = 1'b0;
        smp();
        total_cnt++;
        if (dreq.valid !== 1'b0 || store_done !== 1'b0 || dut.state_q !== ARB_IDLE)
            $display("FAIL t6_abandon: got dv%b sd%b st%0d want dv0 sd0 st0",
                     dreq.valid, store_done, dut.state_q);
        else pass_cnt++;
        nx();
        smp();
        total_cnt++;
        if (store_done !== 1'b0 || dreq.valid !== 1'b0)
            $display("FAIL t6_quiet: got sd%b dv%b want sd0 dv0", store_done, dreq.valid);
        else pass_cnt++;
        nx();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        load_req  = '{valid: 1'b0, addr: 64'h0, size: 3'd0};
        store_req = '{valid: 1'b0, addr: 64'h0, size: 3'd0, strobe: 8'h00, data: 64'h0};
        dresp     = '{data_ok: 1'b0, data: 64'h0};
        nx();
        test_reset();
        test_single_load();
        test_raw_order();
        test_starvation();
        test_flush();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
